// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control path: opcodes,
// ALU operation and operand-select codes, and the control FSM state encoding.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  // States that stall on a memory-ready handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle main control FSM for the RV32 datapath.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   FETCH    | request instruction, PC+4 and IR load when imem_ready
//   DECODE   | opcode/funct legality check, branch target into ALUOut
//   EXEC_R   | register-register ALU operation
//   EXEC_I   | register-immediate ALU operation
//   MEM_ADDR | effective address for lw/sw
//   MEM_RD   | data read, held until dmem_ready
//   MEM_WR   | data write, held until dmem_ready
//   WB_ALU   | write ALUOut to rd
//   WB_MEM   | write load data to rd
//   BRANCH   | beq compare, conditional PC update
//   TRAP     | illegal instruction or memory timeout, held until reset
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic [1:0]  ALUOp,
  output logic [3:0]  Funct,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        imem_req,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        illegal,
  output logic [3:0]  state
);

  localparam logic              TIMEOUT_EN = (WAIT_MAX != 0);
  localparam logic [WAIT_W:0]   WAIT_LIM   = (WAIT_W+1)'(WAIT_MAX);

  state_t            cur, nxt;
  logic [31:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   wait_cnt_inc;
  logic              ready_now;
  logic              waiting;
  logic              timeout;
  logic [3:0]        funct_r;
  logic [2:0]        funct3;
  logic              r_ok;
  logic              i_ok;
  logic              unused_ir_bits;

  assign funct3         = ir[14:12];
  assign funct_r        = {ir[30], ir[14:12]};
  assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};
  assign state          = cur;
  assign wait_cnt_inc   = {1'b0, wait_cnt} + {{WAIT_W{1'b0}}, 1'b1};

  // Stall detection and timeout: trap once the stalled-cycle count would hit WAIT_MAX.
  always_comb begin
    ready_now = (cur == S_FETCH) ? imem_ready : dmem_ready;
    waiting   = is_wait_state(cur) && !ready_now;
    timeout   = TIMEOUT_EN && waiting && (wait_cnt_inc == WAIT_LIM);
    r_ok      = (funct_r == 4'b0000) || (funct_r == 4'b1000) ||
                (funct_r == 4'b0111) || (funct_r == 4'b0110);
    i_ok      = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Instruction register, loaded only on an accepted fetch.
  always_ff @(posedge clk) begin
    if (reset)                              ir <= '0;
    else if (cur == S_FETCH && imem_ready)  ir <= instr;
  end

  // Wait counter: clears on any state change, saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (reset)                                        wait_cnt <= '0;
    else if (cur != nxt)                              wait_cnt <= '0;
    else if (waiting && wait_cnt != {WAIT_W{1'b1}})   wait_cnt <= wait_cnt_inc[WAIT_W-1:0];
  end

  // Next-state logic.
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH: begin
        if (imem_ready)   nxt = S_DECODE;
        else if (timeout) nxt = S_TRAP;
      end
      S_DECODE: begin
        case (ir[6:0])
          OP_R:               nxt = r_ok ? S_EXEC_R : S_TRAP;
          OP_I:               nxt = i_ok ? S_EXEC_I : S_TRAP;
          OP_LOAD, OP_STORE:  nxt = S_MEM_ADDR;
          OP_BRANCH:          nxt = (funct3 == 3'b000) ? S_BRANCH : S_TRAP;
          default:            nxt = S_TRAP;
        endcase
      end
      S_EXEC_R:   nxt = S_WB_ALU;
      S_EXEC_I:   nxt = S_WB_ALU;
      S_MEM_ADDR: nxt = (ir[6:0] == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (dmem_ready)   nxt = S_WB_MEM;
        else if (timeout) nxt = S_TRAP;
      end
      S_MEM_WR: begin
        if (dmem_ready)   nxt = S_FETCH;
        else if (timeout) nxt = S_TRAP;
      end
      S_WB_ALU:   nxt = S_FETCH;
      S_WB_MEM:   nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_TRAP;
    endcase
  end

  // Moore output decode; FETCH IR/PC loads follow imem_ready; reset kills all write strobes.
  always_comb begin
    ALUOp       = ALUOP_ADD;
    Funct       = 4'b0000;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RS2;
    imem_req    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    illegal     = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        IRWrite  = imem_ready;
        PCWrite  = imem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM;
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        Funct   = funct_r;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        Funct   = {1'b0, funct3};
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: MemRead  = 1'b1;
      S_MEM_WR: MemWrite = 1'b1;
      S_WB_ALU: RegWrite = 1'b1;
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    if (reset) begin
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed and random instruction streams
// compared cycle by cycle against an instruction-level reference model.
module tb_multicycle_control;
  import riscv_ctrl_pkg::*;

  localparam int WMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready;
  logic [1:0]  ALUOp;
  logic [3:0]  Funct;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        imem_req, IRWrite, PCWrite, PCWriteCond;
  logic        MemRead, MemWrite, MemtoReg, RegWrite, illegal;
  logic [3:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_MAX(WMAX), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ALUOp(ALUOp), .Funct(Funct), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .imem_req(imem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal(illegal), .state(state)
  );

  wire [17:0] obs = {ALUOp, Funct, ALUSrcA, ALUSrcB, imem_req, IRWrite, PCWrite,
                     PCWriteCond, MemRead, MemWrite, MemtoReg, RegWrite, illegal};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  // Output table per state, written straight from the control-signal listing.
  function automatic logic [17:0] exp_out(input state_t s, input logic [31:0] ir,
                                          input logic irdy, input logic rst);
    logic [1:0] aop;  logic [3:0] fn;  logic srca;  logic [1:0] srcb;
    logic req, irw, pcw, pcc, mr, mw, m2r, rw, ill;
    aop = 2'b00; fn = 4'b0000; srca = 1'b0; srcb = 2'b00;
    req = 0; irw = 0; pcw = 0; pcc = 0; mr = 0; mw = 0; m2r = 0; rw = 0; ill = 0;
    case (s)
      S_FETCH:    begin req = 1; srcb = 2'b01; irw = irdy; pcw = irdy; end
      S_DECODE:   srcb = 2'b10;
      S_EXEC_R:   begin srca = 1; aop = 2'b10; fn = {ir[30], ir[14:12]}; end
      S_EXEC_I:   begin srca = 1; srcb = 2'b10; aop = 2'b10; fn = {1'b0, ir[14:12]}; end
      S_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
      S_MEM_RD:   mr = 1;
      S_MEM_WR:   mw = 1;
      S_WB_ALU:   rw = 1;
      S_WB_MEM:   begin rw = 1; m2r = 1; end
      S_BRANCH:   begin srca = 1; aop = 2'b01; pcc = 1; end
      S_TRAP:     ill = 1;
      default:    ill = 1;
    endcase
    if (rst) begin irw = 0; pcw = 0; pcc = 0; mr = 0; mw = 0; rw = 0; end
    return {aop, fn, srca, srcb, req, irw, pcw, pcc, mr, mw, m2r, rw, ill};
  endfunction

  // One clock: drive at the falling edge, check 1 time unit later.
  task automatic cycle(input string tag, input state_t es, input logic [31:0] ir,
                       input logic [31:0] ir_in, input logic irdy, input logic drdy);
    @(negedge clk);
    reset = 1'b0; instr = ir_in; imem_ready = irdy; dmem_ready = drdy;
    #1;
    chk({tag, "/state"}, 32'(state), 32'(es));
    chk({tag, "/out"}, 32'(obs), 32'(exp_out(es, ir, irdy, 1'b0)));
  endtask

  // Reset for two edges; strobes must be masked while reset is high.
  task automatic do_reset(input string tag, input state_t es, input logic chk_first);
    @(negedge clk);
    reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; instr = $urandom;
    #1;
    if (chk_first) chk({tag, "/rst_out"}, 32'(obs), 32'(exp_out(es, 32'h0, 1'b1, 1'b1)));
    @(negedge clk);
    #1;
    chk({tag, "/rst_state"}, 32'(state), 32'(S_FETCH));
    chk({tag, "/rst_fetch"}, 32'(obs), 32'(exp_out(S_FETCH, 32'h0, 1'b1, 1'b1)));
  endtask

  // Reference model: expected state trace of one instruction from its class.
  task automatic run_instr(input string tag, input logic [31:0] ir,
                           input int fstall, input int mstall);
    state_t q[$];
    logic   iq[$];
    logic   dq[$];
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] f4;
    logic trapped;
    op = ir[6:0]; f3 = ir[14:12]; f4 = {ir[30], ir[14:12]}; trapped = 1'b0;
    for (int i = 0; i < fstall; i++) begin q.push_back(S_FETCH); iq.push_back(1'b0); dq.push_back(1'($urandom)); end
    q.push_back(S_FETCH);  iq.push_back(1'b1); dq.push_back(1'($urandom));
    q.push_back(S_DECODE); iq.push_back(1'($urandom)); dq.push_back(1'($urandom));
    if (op == 7'b0110011 && (f4 == 4'b0000 || f4 == 4'b1000 || f4 == 4'b0111 || f4 == 4'b0110)) begin
      q.push_back(S_EXEC_R); q.push_back(S_WB_ALU);
    end else if (op == 7'b0010011 && (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110)) begin
      q.push_back(S_EXEC_I); q.push_back(S_WB_ALU);
    end else if (op == 7'b0000011 || op == 7'b0100011) begin
      q.push_back(S_MEM_ADDR);
      for (int i = 0; i <= mstall; i++)
        q.push_back(op == 7'b0000011 ? S_MEM_RD : S_MEM_WR);
      if (op == 7'b0000011) q.push_back(S_WB_MEM);
    end else if (op == 7'b1100011 && f3 == 3'b000) begin
      q.push_back(S_BRANCH);
    end else begin
      trapped = 1'b1;
      repeat (3) q.push_back(S_TRAP);
    end
    // Ready lines for the post-decode states: only MEM_RD/MEM_WR stall on dmem_ready.
    begin
      int k;
      k = 0;
      for (int i = iq.size(); i < q.size(); i++) begin
        iq.push_back(1'($urandom));
        if (q[i] == S_MEM_RD || q[i] == S_MEM_WR) begin
          dq.push_back(k < mstall ? 1'b0 : 1'b1);
          k++;
        end else dq.push_back(1'($urandom));
      end
    end
    for (int i = 0; i < q.size(); i++)
      cycle(tag, q[i], ir, (q[i] == S_FETCH && iq[i]) ? ir : $urandom, iq[i], dq[i]);
    if (trapped) do_reset(tag, S_TRAP, 1'b1);
  endtask

  function automatic logic [31:0] mk_r(input logic b30, input logic [2:0] f3);
    return {1'b0, b30, 5'b0, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] ir;
    logic [3:0]  legal_r [4];
    int kind;
    legal_r[0] = 4'b0000; legal_r[1] = 4'b1000; legal_r[2] = 4'b0111; legal_r[3] = 4'b0110;
    reset = 1'b1; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    do_reset("init", S_FETCH, 1'b0);

    run_instr("add", 32'h002081B3, 0, 0);
    run_instr("sub", 32'h402081B3, 0, 0);
    run_instr("lw_stall", 32'h0080A283, 0, 3);
    run_instr("sw", 32'h0020A223, 0, 0);
    run_instr("beq", 32'h00208463, 0, 0);
    run_instr("addi_b30", 32'h4000_0093, 3, 0);
    run_instr("xor_illegal", 32'h0020C1B3, 0, 0);

    // Fetch timeout: WMAX stalled cycles then TRAP.
    for (int i = 0; i < WMAX; i++) cycle("timeout", S_FETCH, 32'h0, $urandom, 1'b0, 1'($urandom));
    cycle("timeout", S_TRAP, 32'h0, $urandom, 1'b1, 1'b1);
    cycle("timeout", S_TRAP, 32'h0, $urandom, 1'b0, 1'b0);
    do_reset("timeout", S_TRAP, 1'b1);

    // Reset in the middle of a stalled load.
    ir = 32'h0080A283;
    cycle("rst_mid", S_FETCH, ir, ir, 1'b1, 1'b0);
    cycle("rst_mid", S_DECODE, ir, $urandom, 1'b0, 1'b0);
    cycle("rst_mid", S_MEM_ADDR, ir, $urandom, 1'b0, 1'b0);
    cycle("rst_mid", S_MEM_RD, ir, $urandom, 1'b0, 1'b0);
    do_reset("rst_mid", S_MEM_RD, 1'b1);

    repeat (60) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 8: ir = mk_r(legal_r[$urandom_range(0, 3)][3], legal_r[$urandom_range(0, 3)][2:0]);
        1:    ir = mk_r(1'($urandom), 3'($urandom));
        2:    ir = {12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'b0010011};
        3, 9: ir = {12'($urandom), 5'($urandom), 3'b010, 5'($urandom), 7'b0000011};
        4:    ir = {7'($urandom), 5'($urandom), 5'($urandom), 3'b010, 5'($urandom), 7'b0100011};
        5:    ir = {7'($urandom), 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b1100011};
        6:    ir = {7'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'b1100011};
        default: ir = $urandom;
      endcase
      run_instr("rand", ir, $urandom_range(0, WMAX - 1), $urandom_range(0, WMAX - 1));
    end
    cycle("final", S_FETCH, 32'h0, $urandom, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle main control FSM for the RISC-V datapath.
- Drives the ALUOp/Funct pair consumed by the ALU control block, plus datapath strobes: mux selects, PC/IR/register-file/memory enables.
- Decodes RV32 R-type (add/sub/and/or), I-ALU (addi/andi/ori), lw, sw and beq.
- Sequences each instruction over fetch/decode/execute/memory/writeback and stalls on memory-ready handshakes.

Parameters:
- WAIT_MAX, 255: maximum cycles spent waiting on imem_ready/dmem_ready before trapping; 0 disables the timeout.
- WAIT_W, 8: width of the wait counter; must satisfy WAIT_MAX < 2^WAIT_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- instr  in  32  instruction word; sampled into the internal IR in FETCH when imem_ready=1
- imem_ready  in  1  instruction memory has valid data
- dmem_ready  in  1  data memory access complete
- ALUOp  out  2  00 add, 01 subtract (branch compare), 10 decode via Funct
- Funct  out  4  {instr[30], funct3} to ALU control
- ALUSrcA  out  1  0 = PC, 1 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- imem_req  out  1  fetch request
- IRWrite  out  1  load instruction register
- PCWrite  out  1  unconditional PC update
- PCWriteCond  out  1  PC update if ALU zero
- MemRead  out  1  data read strobe
- MemWrite  out  1  data write strobe
- MemtoReg  out  1  writeback source: 1 = memory, 0 = ALUOut
- RegWrite  out  1  register file write
- illegal  out  1  sticky trap indicator
- state  out  4  current FSM state (debug)

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset, from any state including mid-access:
  - next state FETCH; IR = 0; wait counter = 0; illegal = 0.
  - While reset is high, all write strobes (IRWrite, PCWrite, PCWriteCond, MemRead, MemWrite, RegWrite) are forced to 0.
- Output style: outputs are Moore decodes of state, except IRWrite/PCWrite in FETCH, which equal imem_ready.
- Funct:
  - {IR[30], IR[14:12]} in EXEC_R.
  - {1'b0, IR[14:12]} in EXEC_I (bit 30 is immediate data).
  - 4'b0000 in all other states.
- Default output values when not listed: ALUOp=00, ALUSrcA=0, ALUSrcB=00, all strobes 0.
- States, outputs and transitions:
  - FETCH (reset state): imem_req=1, ALUSrcB=01, ALUOp=00. If imem_ready: IRWrite=1, PCWrite=1 (PC+4), go to DECODE; else stay.
  - DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut). Next state by IR[6:0]:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 with funct3=000 -> BRANCH
    - anything else -> TRAP
  - Funct legality, checked in DECODE: R-type Funct must be in {0000, 1000, 0111, 0110}; I-ALU funct3 must be in {000, 111, 110}. Otherwise -> TRAP.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_ALU.
  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=10 -> WB_ALU.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Load -> MEM_RD; store -> MEM_WR.
  - MEM_RD: MemRead=1 held until dmem_ready, then -> WB_MEM.
  - MEM_WR: MemWrite=1 held until dmem_ready, then -> FETCH.
  - WB_ALU: RegWrite=1, MemtoReg=0 -> FETCH.
  - WB_MEM: RegWrite=1, MemtoReg=1 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 -> FETCH.
  - TRAP: illegal=1, all strobes 0; held until reset.
- Latency (minimum, with ready=1 throughout): R/I-ALU 4 cycles, lw 5, sw 4, beq 3.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle spent in FETCH/MEM_RD/MEM_WR with ready=0.
  - If WAIT_MAX != 0 and the counter reaches WAIT_MAX while ready is still 0, next state is TRAP.
  - If ready=1 arrives in the same cycle the counter reaches WAIT_MAX, ready wins.
- IR is written only in FETCH when imem_ready=1; changes on instr at any other time have no effect.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH)
  - ALUOp codes
  - ALUSrcB codes
  - state enumeration, 4-bit encoding
- No sub-module; the FSM, IR and wait counter live in one module.

Test Plan:
- R-type: reset, then instr=0x002081B3 (add x3,x1,x2) with ready=1 -> exactly 4 cycles; EXEC_R shows ALUOp=10, Funct=0000; WB_ALU shows RegWrite=1, MemtoReg=0.
- R-type sub: instr=0x402081B3 -> Funct=1000 in EXEC_R.
- Load with stall: instr=0x0080A283 (lw x5,8(x1)), dmem_ready low for 3 cycles -> MemRead held 4 cycles; WB_MEM RegWrite=1, MemtoReg=1; 8 cycles total.
- Store and branch:
  - instr=0x0020A223 (sw) -> MemWrite=1 for 1 cycle, RegWrite never 1.
  - instr=0x00208463 (beq) -> BRANCH shows ALUOp=01, PCWriteCond=1, Funct=0000.
- Illegal: instr=0x0020C1B3 (xor, Funct 0100) -> TRAP after DECODE, illegal=1 held, strobes 0. Reset pulse -> FETCH, illegal=0.
- Timeout and reset: WAIT_MAX=4 with imem_ready stuck low -> TRAP after 4 stalled cycles. Separately, reset asserted mid-MEM_RD -> FETCH next edge, MemRead=0 during reset.
